// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues req/ack reads to instruction
// memory and buffers {pc, instruction} pairs in a small FIFO toward decode.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] fetch_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] ent_pc_q   [DEPTH];
    logic [31:0] ent_inst_q [DEPTH];

    logic        push;
    logic        pop;
    logic        space;
    logic [31:0] rpc_aligned;
    logic [31:0] pc_plus4;
    logic        unused_rpc_bits;

    assign rpc_aligned     = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_bits = ^redirect_pc[1:0];
    assign pc_plus4        = pc_q + 32'd4;

    // Only a live (non-discarded) request pushes; a redirect kills the word it acks.
    assign push = (state_q == ST_REQ) && imem_ack && !redirect;
    assign pop  = (count_q != '0) && inst_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
    end

    // Space is judged on the post-push/pop occupancy so a request never overfills.
    assign space = (count_d < CW'(DEPTH));

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    pc_d = rpc_aligned;
                end else if (space) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d    = rpc_aligned;
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        pc_d = pc_plus4;
                        if (space) begin
                            addr_d = pc_plus4;
                        end else begin
                            req_d   = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end else if (redirect) begin
                    pc_d    = rpc_aligned;
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    pc_d = rpc_aligned;
                end
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst) begin
                    ent_pc_q[gi]   <= '0;
                    ent_inst_q[gi] <= '0;
                end else if (push && (wr_ptr_q == AW'(gi))) begin
                    ent_pc_q[gi]   <= addr_q;
                    ent_inst_q[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign fetch_pc   = pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = ent_inst_q[rd_ptr_q];
    assign inst_pc    = ent_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based behavioural model.
module tb_ifetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC0  = 32'h0000_0000;
    localparam logic [31:0] MASK  = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] fetch_pc;

    logic        rmode;
    logic [31:0] rdata_rand;
    logic        chk_en = 1'b0;
    logic        verbose = 1'b1;
    int          total = 0;
    int          bad = 0;

    // Behavioural model: a queue of {pc, inst} plus the outstanding-request view.
    logic [63:0] m_q[$];
    logic        m_req;
    logic        m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_fpc;

    assign imem_rdata = rmode ? (imem_addr ^ MASK) : rdata_rand;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC0)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .fetch_pc   (fetch_pc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic        do_pop;
        logic        do_push;
        logic [31:0] rpc;
        int          sz;
        rpc = {redirect_pc[31:2], 2'b00};
        if (!rst) begin
            m_q.delete();
            m_req  = 1'b0;
            m_drop = 1'b0;
            m_addr = RPC0;
            m_fpc  = RPC0;
        end else begin
            do_pop  = (m_q.size() > 0) && inst_ready;
            do_push = m_req && !m_drop && imem_ack && !redirect;
            if (do_pop && verbose && !redirect)
                $display("pop  pc=%h inst=%h", m_q[0][63:32], m_q[0][31:0]);
            if (redirect) begin
                m_q.delete();
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (do_push) m_q.push_back({m_addr, imem_rdata});
            end
            sz = m_q.size();
            if (!m_req) begin
                if (redirect) m_fpc = rpc;
                else if (sz < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_fpc;
                end
            end else if (!m_drop) begin
                if (imem_ack && redirect) begin
                    m_fpc = rpc;
                    m_req = 1'b0;
                end else if (imem_ack) begin
                    m_fpc = m_fpc + 32'd4;
                    if (sz < DEPTH) m_addr = m_fpc;
                    else m_req = 1'b0;
                end else if (redirect) begin
                    m_fpc  = rpc;
                    m_drop = 1'b1;
                end
            end else begin
                if (redirect) m_fpc = rpc;
                if (imem_ack) begin
                    m_req  = 1'b0;
                    m_drop = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_req", {31'd0, imem_req}, {31'd0, m_req});
                if (m_req) chk("m_addr", imem_addr, m_addr);
                chk("m_fetch_pc", fetch_pc, m_fpc);
                chk("m_valid", {31'd0, inst_valid}, {31'd0, m_q.size() > 0});
                if (m_q.size() > 0) begin
                    chk("m_inst_pc", inst_pc, m_q[0][63:32]);
                    chk("m_inst", inst, m_q[0][31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b1; inst_ready = 1'b1; rmode = 1'b1; rdata_rand = '0;

        // Reset with ack asserted, then release and stream.
        step();
        chk_en = 1'b1;
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        rst = 1'b1;
        step();
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("str_valid", {31'd0, inst_valid}, 32'd1);
            chk("str_pc", inst_pc, 32'(4 * k));
            chk("str_inst", inst, 32'(4 * k) ^ MASK);
        end

        // Backpressure: four pushes fill the FIFO, then fetch stalls.
        rst = 1'b0; inst_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        repeat (4) step();
        chk("bp_req", {31'd0, imem_req}, 32'd0);
        chk("bp_fetch_pc", fetch_pc, 32'd16);
        chk("bp_head", inst_pc, 32'd0);
        repeat (2) step();
        chk("bp_hold_req", {31'd0, imem_req}, 32'd0);
        chk("bp_hold_head", inst_pc, 32'd0);
        inst_ready = 1'b1;
        step();
        chk("bp_resume_req", {31'd0, imem_req}, 32'd1);
        chk("bp_resume_addr", imem_addr, 32'd16);
        chk("bp_pop1", inst_pc, 32'd4);
        step(); chk("bp_pop2", inst_pc, 32'd8);
        step(); chk("bp_pop3", inst_pc, 32'd12);
        step(); chk("bp_pop4", inst_pc, 32'd16);

        // Redirect while the request at address 8 is stalled.
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("rif_addr8", imem_addr, 32'd8);
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        step();
        chk("rif_hold_addr", imem_addr, 32'd8);
        chk("rif_hold_req", {31'd0, imem_req}, 32'd1);
        chk("rif_flush", {31'd0, inst_valid}, 32'd0);
        chk("rif_fpc", fetch_pc, 32'h100);
        redirect = 1'b0;
        repeat (2) step();
        chk("rif_still8", imem_addr, 32'd8);
        imem_ack = 1'b1;
        step();
        chk("rif_drop_req", {31'd0, imem_req}, 32'd0);
        chk("rif_drop_valid", {31'd0, inst_valid}, 32'd0);
        step();
        chk("rif_new_addr", imem_addr, 32'h100);
        step();
        chk("rif_first_pc", inst_pc, 32'h100);
        chk("rif_first_inst", inst, 32'h100 ^ MASK);

        // Redirect coincident with ack and pop while the FIFO holds two entries.
        rst = 1'b0; inst_ready = 1'b0;
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("co_head", inst_pc, 32'd0);
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        chk("co_valid", {31'd0, inst_valid}, 32'd0);
        chk("co_req", {31'd0, imem_req}, 32'd0);
        redirect = 1'b0;
        step();
        chk("co_addr", imem_addr, 32'h200);
        step();
        chk("co_pc", inst_pc, 32'h200);

        // Address wrap and redirect_pc alignment.
        rst = 1'b0;
        step();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("wr_fpc", fetch_pc, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        step(); chk("wr_pc_top", inst_pc, 32'hFFFF_FFFC);
        step(); chk("wr_pc_zero", inst_pc, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h103;
        step();
        chk("al_fpc", fetch_pc, 32'h100);
        redirect = 1'b0;
        step(); chk("al_addr", imem_addr, 32'h100);
        step(); chk("al_pc", inst_pc, 32'h100);

        // Random traffic against the model.
        verbose = 1'b0; rmode = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            int rdy_pct;
            rdy_pct = ((n / 500) % 2 == 0) ? 80 : 25;
            rst         = ($urandom_range(0, 299) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            imem_ack    = ($urandom_range(0, 9) < 6);
            rdata_rand  = $urandom;
            inst_ready  = ($urandom_range(0, 99) < rdy_pct);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
